// File: rtl/multdiv_issue_ctrl.sv
// -----------------------------------------------------------------------------
// multdiv_issue_ctrl
//
// Sequences one multiply or divide between the execute stage and the
// multiply/divide controller. An accepted instruction has its operands and
// destination register captured. A single start pulse is sent to the
// controller. The pipeline is stalled until the controller reports ready or
// the wait budget runs out. Exactly one register-file write then carries the
// result or an rstatus code.
//
// Ports
//   clock, reset                 clock and synchronous active-high reset
//   issue_valid, is_mul, is_div  decoded instruction from execute
//   rd_in, operand_a, operand_b  destination register and source operands
//   md_result, md_exception,     controller completion interface
//   md_ready
//   mul, div                     one-cycle start pulses to the controller
//   data_operandA/B              held operands presented to the controller
//   stall                        combinational pipeline freeze
//   busy                         registered, state is not IDLE
//   wb_valid, wb_rd, wb_data     registered register-file write port
//   timeout                      current completion was forced by timeout
// -----------------------------------------------------------------------------
module multdiv_issue_ctrl #(
    parameter int TIMEOUT      = 40,
    parameter int RSTATUS_REG  = 30,
    parameter int MUL_EXC_CODE = 4,
    parameter int DIV_EXC_CODE = 5,
    parameter int TMO_EXC_CODE = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        is_mul,
    input  logic        is_div,
    input  logic [4:0]  rd_in,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        mul,
    output logic        div,
    output logic [31:0] data_operandA,
    output logic [31:0] data_operandB,
    output logic        stall,
    output logic        busy,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        timeout
);

    localparam logic [4:0]  RSTATUS_ADDR = 5'(RSTATUS_REG);
    localparam logic [31:0] MUL_CODE     = 32'(MUL_EXC_CODE);
    localparam logic [31:0] DIV_CODE     = 32'(DIV_EXC_CODE);
    localparam logic [31:0] TMO_CODE     = 32'(TMO_EXC_CODE);
    // The counter is compared before its increment, so the last WAIT
    // cycle is the one where it still holds TIMEOUT-1.
    localparam logic [7:0]  WAIT_LAST    = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        op_mul_q, op_mul_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mul_q, mul_d;
    logic        div_q, div_d;
    logic        busy_q, busy_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        timeout_q, timeout_d;
    logic        stall_c;

    always_comb begin
        state_d    = state_q;
        op_mul_d   = op_mul_q;
        rd_d       = rd_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        cnt_d      = cnt_q;
        mul_d      = 1'b0;
        div_d      = 1'b0;
        wb_valid_d = 1'b0;
        wb_rd_d    = 5'd0;
        wb_data_d  = 32'd0;
        timeout_d  = 1'b0;
        stall_c    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (issue_valid && (is_mul || is_div)) begin
                    // Multiply takes priority if decode flags both.
                    op_mul_d = is_mul;
                    rd_d     = rd_in;
                    opa_d    = operand_a;
                    opb_d    = operand_b;
                    // The start pulse is registered so that it lines up
                    // with the START cycle.
                    mul_d    = is_mul;
                    div_d    = ~is_mul;
                    stall_c  = 1'b1;
                    state_d  = S_START;
                end
            end
            S_START: begin
                // md_ready may still be high from the previous operation,
                // so it is deliberately not looked at here.
                cnt_d   = 8'd0;
                stall_c = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                if (md_ready) begin
                    // Ready beats a coincident timeout.
                    state_d = S_WB;
                    if (md_exception) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = RSTATUS_ADDR;
                        wb_data_d  = op_mul_q ? MUL_CODE : DIV_CODE;
                    end else begin
                        // Writes to r0 are suppressed.
                        wb_valid_d = (rd_q != 5'd0);
                        wb_rd_d    = rd_q;
                        wb_data_d  = md_result;
                    end
                end else if (cnt_q == WAIT_LAST) begin
                    state_d    = S_WB;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = RSTATUS_ADDR;
                    wb_data_d  = TMO_CODE;
                    timeout_d  = 1'b1;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_mul_q   <= 1'b0;
            rd_q       <= 5'd0;
            opa_q      <= 32'd0;
            opb_q      <= 32'd0;
            cnt_q      <= 8'd0;
            mul_q      <= 1'b0;
            div_q      <= 1'b0;
            busy_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_mul_q   <= op_mul_d;
            rd_q       <= rd_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            cnt_q      <= cnt_d;
            mul_q      <= mul_d;
            div_q      <= div_d;
            busy_q     <= busy_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            timeout_q  <= timeout_d;
        end
    end

    // A reset arriving in the START or WB cycle must not let a start
    // pulse or a register write escape in that same cycle.
    assign mul           = mul_q & ~reset;
    assign div           = div_q & ~reset;
    assign wb_valid      = wb_valid_q & ~reset;
    assign timeout       = timeout_q & ~reset;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign data_operandA = opa_q;
    assign data_operandB = opb_q;
    assign busy          = busy_q;
    assign stall         = stall_c;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multdiv_issue_ctrl
//
// Table of complete mul/div transactions applied back to back. The driver
// pushes each expected write to a scoreboard queue. A monitor pops and
// compares it when the DUT is in its WB cycle (busy=1, stall=0). Hand-written
// sequences cover reset behaviour.
// -----------------------------------------------------------------------------
module tb_multdiv_issue_ctrl;

    localparam int TIMEOUT = 40;

    logic        clock;
    logic        reset;
    logic        issue_valid;
    logic        is_mul;
    logic        is_div;
    logic [4:0]  rd_in;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ready;
    logic        mul;
    logic        div;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        stall;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        timeout;

    multdiv_issue_ctrl #(
        .TIMEOUT      (TIMEOUT),
        .RSTATUS_REG  (30),
        .MUL_EXC_CODE (4),
        .DIV_EXC_CODE (5),
        .TMO_EXC_CODE (6)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .is_mul        (is_mul),
        .is_div        (is_div),
        .rd_in         (rd_in),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .md_result     (md_result),
        .md_exception  (md_exception),
        .md_ready      (md_ready),
        .mul           (mul),
        .div           (div),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .stall         (stall),
        .busy          (busy),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .timeout       (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One transaction. ready_t is the cycle, counted from the accept cycle
    // (t=0), in which md_ready is driven high; 0 means never. With stale set,
    // md_ready is held high from t=0 through ready_t. lat is the expected
    // cycle of the WB cycle.
    typedef struct {
        logic        is_mul;
        logic        is_div;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        logic        stale;
        int          ready_t;
        int          lat;
        logic        exp_valid;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        logic        exp_to;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        to;
        int          cyc;
    } exp_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];
    exp_t sb_q [$];
    int   n_vec = 0;
    int   n_err = 0;
    int   gcyc  = 0;

    always @(negedge clock) gcyc <= gcyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // WB cycle monitor: busy high with stall low only happens in WB.
    always @(negedge clock) begin
        exp_t e;
        #1;
        if (!reset && busy && !stall) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wb_unexpected: got WB rd=%0d data=0x%08h, want no completion", wb_rd, wb_data);
            end else begin
                e = sb_q.pop_front();
                chk("wb_valid", 32'(wb_valid), 32'(e.valid));
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_data", wb_data, e.data);
                chk("timeout", 32'(timeout), 32'(e.to));
                chk("wb_cycle", 32'(gcyc), 32'(e.cyc));
            end
        end else if (wb_valid || timeout) begin
            n_vec++;
            n_err++;
            $display("FAIL wb_stray: got wb_valid=%0b timeout=%0b outside WB, want 0", wb_valid, timeout);
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   stall_n;
        int   mul_n;
        int   div_n;
        int   pulse_t;
        @(negedge clock);
        issue_valid  = 1'b1;
        is_mul       = v.is_mul;
        is_div       = v.is_div;
        rd_in        = v.rd;
        operand_a    = v.a;
        operand_b    = v.b;
        md_result    = v.res;
        md_exception = v.exc;
        md_ready     = v.stale;
        #1;
        e.valid = v.exp_valid;
        e.rd    = v.exp_rd;
        e.data  = v.exp_data;
        e.to    = v.exp_to;
        e.cyc   = gcyc + v.lat;
        sb_q.push_back(e);
        stall_n = stall ? 1 : 0;
        mul_n   = mul ? 1 : 0;
        div_n   = div ? 1 : 0;
        pulse_t = (mul || div) ? 0 : -1;
        for (int t = 1; t <= v.lat; t++) begin
            @(negedge clock);
            issue_valid = 1'b0;
            is_mul      = 1'b0;
            is_div      = 1'b0;
            rd_in       = 5'($urandom);
            operand_a   = $urandom;
            operand_b   = $urandom;
            md_ready    = v.stale ? (t <= v.ready_t) : (t == v.ready_t);
            #1;
            if (stall) stall_n++;
            if (mul) mul_n++;
            if (div) div_n++;
            if ((mul || div) && pulse_t < 0) pulse_t = t;
            if (t == 1 || t == v.lat) begin
                chk("operand_a_held", data_operandA, v.a);
                chk("operand_b_held", data_operandB, v.b);
            end
        end
        md_ready = 1'b0;
        chk("stall_cycles", 32'(stall_n), 32'(v.lat));
        chk("mul_pulses", 32'(mul_n), v.is_mul ? 32'd1 : 32'd0);
        chk("div_pulses", 32'(div_n), v.is_mul ? 32'd0 : 32'd1);
        chk("start_cycle", 32'(pulse_t), 32'd1);
        $display("vec %0d: %s rd=%0d a=0x%08h b=0x%08h -> expect wb_valid=%0b rd=%0d data=0x%08h timeout=%0b at +%0d",
                 idx, v.is_mul ? "mul" : "div", v.rd, v.a, v.b,
                 v.exp_valid, v.exp_rd, v.exp_data, v.exp_to, v.lat);
    endtask

    initial begin
        //            mul   div   rd     a              b              res            exc   stale rdy lat val   wrd     wdata          to
        vecs[0] = '{1'b1, 1'b0, 5'd5,  32'd7,         32'hFFFFFFFD,  32'hFFFFFFEB,  1'b0, 1'b0, 21, 22, 1'b1, 5'd5,  32'hFFFFFFEB,  1'b0};
        vecs[1] = '{1'b0, 1'b1, 5'd9,  32'd100,       32'd0,         32'hDEADBEEF,  1'b1, 1'b0, 4,  5,  1'b1, 5'd30, 32'd5,         1'b0};
        vecs[2] = '{1'b1, 1'b0, 5'd12, 32'h7FFFFFFF,  32'd2,         32'hFFFFFFFE,  1'b1, 1'b0, 3,  4,  1'b1, 5'd30, 32'd4,         1'b0};
        vecs[3] = '{1'b1, 1'b0, 5'd0,  32'd3,         32'd4,         32'd12,        1'b0, 1'b0, 2,  3,  1'b0, 5'd0,  32'd12,        1'b0};
        vecs[4] = '{1'b1, 1'b0, 5'd3,  32'd5,         32'd6,         32'd30,        1'b0, 1'b1, 2,  3,  1'b1, 5'd3,  32'd30,        1'b0};
        vecs[5] = '{1'b0, 1'b1, 5'd7,  32'd50,        32'd7,         32'd0,         1'b0, 1'b0, 0,  42, 1'b1, 5'd30, 32'd6,         1'b1};
        vecs[6] = '{1'b0, 1'b1, 5'd8,  32'd9,         32'd3,         32'h00001234,  1'b0, 1'b0, 41, 42, 1'b1, 5'd8,  32'h00001234,  1'b0};
        vecs[7] = '{1'b1, 1'b1, 5'd10, 32'd9,         32'd11,        32'd99,        1'b0, 1'b0, 2,  3,  1'b1, 5'd10, 32'd99,        1'b0};
        vecs[8] = '{1'b0, 1'b1, 5'd0,  32'd1,         32'd0,         32'd0,         1'b1, 1'b0, 5,  6,  1'b1, 5'd30, 32'd5,         1'b0};
        vecs[9] = '{1'b0, 1'b1, 5'd31, 32'd200,       32'd7,         32'd28,        1'b0, 1'b0, 6,  7,  1'b1, 5'd31, 32'd28,        1'b0};

        reset        = 1'b1;
        issue_valid  = 1'b0;
        is_mul       = 1'b0;
        is_div       = 1'b0;
        rd_in        = 5'd0;
        operand_a    = 32'd0;
        operand_b    = 32'd0;
        md_result    = 32'd0;
        md_exception = 1'b0;
        md_ready     = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_mul", 32'(mul), 32'd0);
        chk("rst_div", 32'(div), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_operand_a", data_operandA, 32'd0);
        chk("rst_operand_b", data_operandB, 32'd0);
        reset = 1'b0;

        // Back to back: each vector is accepted in the IDLE cycle after
        // the previous WB.
        for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

        // Reset during WAIT: no write, back to IDLE next cycle.
        @(negedge clock);
        issue_valid = 1'b1;
        is_mul      = 1'b1;
        is_div      = 1'b0;
        rd_in       = 5'd4;
        operand_a   = 32'h11111111;
        operand_b   = 32'h22222222;
        md_ready    = 1'b0;
        @(negedge clock);
        issue_valid = 1'b0;
        is_mul      = 1'b0;
        repeat (3) @(negedge clock);
        md_ready = 1'b1;
        reset    = 1'b1;
        #1;
        chk("rstwait_wb_valid", 32'(wb_valid), 32'd0);
        @(negedge clock);
        reset    = 1'b0;
        md_ready = 1'b0;
        #1;
        chk("rstwait_busy", 32'(busy), 32'd0);
        chk("rstwait_stall", 32'(stall), 32'd0);
        chk("rstwait_wb_valid_after", 32'(wb_valid), 32'd0);
        chk("rstwait_operand_a", data_operandA, 32'd0);
        $display("seq reset-in-WAIT: mul rd=4 aborted, expect IDLE and no write");
        repeat (4) @(negedge clock);

        // Reset in the START cycle: the start pulse must not escape.
        @(negedge clock);
        issue_valid = 1'b1;
        is_div      = 1'b1;
        rd_in       = 5'd6;
        operand_a   = 32'd77;
        operand_b   = 32'd7;
        @(negedge clock);
        issue_valid = 1'b0;
        is_div      = 1'b0;
        reset       = 1'b1;
        #1;
        chk("rststart_div", 32'(div), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rststart_busy", 32'(busy), 32'd0);
        chk("rststart_div_after", 32'(div), 32'd0);
        $display("seq reset-in-START: div rd=6 aborted, expect no start pulse");
        repeat (3) @(negedge clock);

        // Normal operation resumes after a mid-operation reset.
        run_vec(vecs[0], 0);
        repeat (3) @(negedge clock);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
